// File: rtl/zx_video.sv
// Spectrum display generator: video timing, screen RAM fetch, RGBI serialiser, IRQ and contention.
// Defining ZX_VIDEO_FLOATBUS_EN adds the fb floating-bus output.
module zx_video #(
  parameter int unsigned HBLANK_START = 320,
  parameter int unsigned HSYNC_START  = 344,
  parameter int unsigned VSYNC_LINE   = 248
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ce,
  input  logic        model,
  input  logic [2:0]  border,
  output logic        vce,
  output logic [12:0] va,
  input  logic [7:0]  vq,
  output logic        hsync,
  output logic        vsync,
  output logic        hblank,
  output logic        vblank,
  output logic        r,
  output logic        g,
  output logic        b,
  output logic        i,
  output logic        irq,
  output logic        contend
`ifdef ZX_VIDEO_FLOATBUS_EN
  ,
  output logic [7:0]  fb
`endif
);

  localparam logic [8:0] HBlankLo = 9'(HBLANK_START);
  localparam logic [8:0] HBlankHi = 9'(HBLANK_START + 96);
  localparam logic [8:0] HSyncLo  = 9'(HSYNC_START);
  localparam logic [8:0] HSyncHi  = 9'(HSYNC_START + 32);
  localparam logic [8:0] VSyncLo  = 9'(VSYNC_LINE);
  localparam logic [8:0] VSyncHi  = 9'(VSYNC_LINE + 4);
  localparam logic [8:0] VBlankHi = 9'(VSYNC_LINE + 8);

  logic [8:0]  h_count_q, h_count_d, v_count_q, v_count_d, h_max, v_max;
  logic        h_wrap, v_wrap, fetch, disp, hblank_d, vblank_d, pix;
  logic [2:0]  slot;
  logic [4:0]  col;
  logic [7:0]  line;
  logic [7:0]  bitmap_q, attr_q, shift_q, attr_disp_q;
  logic [4:0]  frame_q;
  logic [12:0] va_q;
  logic [2:0]  rgb_d, rgb_q;
  logic        i_d, i_q;
  logic        hsync_q, vsync_q, hblank_q, vblank_q, irq_q, contend_q;

  // Counters beyond the current model's maximum (after a model switch) wrap on the next ce.
  always_comb begin
    h_max     = model ? 9'd455 : 9'd447;
    v_max     = model ? 9'd310 : 9'd311;
    h_wrap    = h_count_q >= h_max;
    v_wrap    = (v_count_q > v_max) || (h_wrap && (v_count_q >= v_max));
    h_count_d = h_wrap ? 9'd0 : h_count_q + 9'd1;
    if (v_wrap) begin
      v_count_d = 9'd0;
    end else if (h_wrap) begin
      v_count_d = v_count_q + 9'd1;
    end else begin
      v_count_d = v_count_q;
    end
  end

  assign slot     = h_count_q[2:0];
  assign col      = h_count_q[7:3];
  assign line     = v_count_q[7:0];
  assign fetch    = (v_count_q < 9'd192) && (h_count_q < 9'd256);
  assign disp     = (v_count_q < 9'd192) && (h_count_q >= 9'd8) && (h_count_q < 9'd264);
  assign hblank_d = (h_count_q >= HBlankLo) && (h_count_q < HBlankHi);
  assign vblank_d = (v_count_q >= VSyncLo) && (v_count_q < VBlankHi);

  always_comb begin
    vce = 1'b0;
    va  = va_q;
    if (reset) begin
      va = '0;
    end else if (fetch && (slot == 3'd0)) begin
      vce = ce;
      va  = {line[7:6], line[2:0], line[5:3], col};
    end else if (fetch && (slot == 3'd2)) begin
      vce = ce;
      va  = {3'b110, line[7:3], col};
    end
  end

  assign pix = shift_q[7] ^ (attr_disp_q[7] & frame_q[4]);

  always_comb begin
    rgb_d = border;
    i_d   = 1'b0;
    if (hblank_d || vblank_d) begin
      rgb_d = 3'b000;
    end else if (disp) begin
      rgb_d = pix ? attr_disp_q[2:0] : attr_disp_q[5:3];
      i_d   = attr_disp_q[6];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      h_count_q   <= '0;
      v_count_q   <= '0;
      frame_q     <= '0;
      va_q        <= '0;
      bitmap_q    <= '0;
      attr_q      <= '0;
      shift_q     <= '0;
      attr_disp_q <= '0;
      rgb_q       <= '0;
      i_q         <= 1'b0;
      hsync_q     <= 1'b0;
      vsync_q     <= 1'b0;
      hblank_q    <= 1'b0;
      vblank_q    <= 1'b0;
      irq_q       <= 1'b1;
      contend_q   <= 1'b0;
    end else if (ce) begin
      h_count_q <= h_count_d;
      v_count_q <= v_count_d;
      if (v_wrap) frame_q <= frame_q + 5'd1;
      va_q <= va;
      if (fetch && (slot == 3'd1)) bitmap_q <= vq;
      if (fetch && (slot == 3'd3)) attr_q <= vq;
      // Loading the next column wins over the shift on the column's last pixel.
      if (fetch && (slot == 3'd7)) begin
        shift_q     <= bitmap_q;
        attr_disp_q <= attr_q;
      end else begin
        shift_q <= {shift_q[6:0], 1'b0};
      end
      rgb_q     <= rgb_d;
      i_q       <= i_d;
      hsync_q   <= (h_count_q >= HSyncLo) && (h_count_q < HSyncHi);
      vsync_q   <= (v_count_q >= VSyncLo) && (v_count_q < VSyncHi);
      hblank_q  <= hblank_d;
      vblank_q  <= vblank_d;
      irq_q     <= !((v_count_q == VSyncLo) && (h_count_q < 9'd64));
      contend_q <= fetch && (slot <= 3'd5);
    end
  end

  assign {g, r, b} = rgb_q;
  assign i         = i_q;
  assign hsync     = hsync_q;
  assign vsync     = vsync_q;
  assign hblank    = hblank_q;
  assign vblank    = vblank_q;
  assign irq       = irq_q;
  assign contend   = contend_q;

`ifdef ZX_VIDEO_FLOATBUS_EN
  always_comb begin
    fb = 8'hFF;
    if (!reset && fetch) begin
      case (slot)
        3'd1, 3'd3: fb = vq;
        3'd2:       fb = bitmap_q;
        3'd4:       fb = attr_q;
        default:    fb = 8'hFF;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_zx_video.sv
// Bench for zx_video: random screen RAM and ce against a position/pixel reference model.
// Vsync line is moved to 4 so sync, blank and irq are reached within a short run.
module tb_zx_video;

  localparam int VL = 4;

  logic        clock = 1'b0;
  logic        reset, ce, model;
  logic [2:0]  border;
  logic        vce;
  logic [12:0] va;
  logic [7:0]  vq = 8'h00;
  logic        hsync, vsync, hblank, vblank, r, g, b, i, irq, contend;
`ifdef ZX_VIDEO_FLOATBUS_EN
  logic [7:0]  fb;
`endif

  zx_video #(.VSYNC_LINE(VL)) dut (
    .clock   (clock),
    .reset   (reset),
    .ce      (ce),
    .model   (model),
    .border  (border),
    .vce     (vce),
    .va      (va),
    .vq      (vq),
    .hsync   (hsync),
    .vsync   (vsync),
    .hblank  (hblank),
    .vblank  (vblank),
    .r       (r),
    .g       (g),
    .b       (b),
    .i       (i),
    .irq     (irq),
    .contend (contend)
`ifdef ZX_VIDEO_FLOATBUS_EN
    ,
    .fb      (fb)
`endif
  );

  always #5 clock = ~clock;

  logic [7:0] mem [0:8191];
  always @(posedge clock) if (vce) vq <= mem[va];

  int total = 0;
  int bad   = 0;

  // Reference model state: beam position, frame number, last video address, expected outputs.
  int         ref_h, ref_v, ref_frame, last_va;
  logic [9:0] exp_out;  // {hsync,vsync,hblank,vblank,r,g,b,i,irq,contend}
  localparam logic [9:0] RstOut = 10'b00_0000_0010;

  function automatic int bm_addr(int y, int c);
    return 2048 * (y / 64) + 256 * (y % 8) + 32 * ((y / 8) % 8) + c;
  endfunction

  function automatic int at_addr(int y, int c);
    return 6144 + 32 * (y / 8) + c;
  endfunction

  function automatic bit fetching(int h, int v);
    return (v < 192) && (h < 256);
  endfunction

  function automatic int va_model(int h, int v, int last);
    if (fetching(h, v) && (h % 8 == 0)) return bm_addr(v, h / 8);
    if (fetching(h, v) && (h % 8 == 2)) return at_addr(v, h / 8);
    return last;
  endfunction

  function automatic int hmax_of(logic m);
    return m ? 455 : 447;
  endfunction

  function automatic int vmax_of(logic m);
    return m ? 310 : 311;
  endfunction

  function automatic int next_v(int h, int v, logic m);
    if (v > vmax_of(m)) return 0;
    if (h >= hmax_of(m)) return (v >= vmax_of(m)) ? 0 : v + 1;
    return v;
  endfunction

  function automatic logic [9:0] outs_at(int h, int v, logic [2:0] bord, int frame);
    logic       hs, vs, hb, vb, irq_v, con, ii, bitv, fl, pix;
    logic [7:0] bm, at;
    logic [2:0] rgb;
    int         x;
    hs    = (h >= 344) && (h < 376);
    hb    = (h >= 320) && (h < 416);
    vs    = (v >= VL) && (v < VL + 4);
    vb    = (v >= VL) && (v < VL + 8);
    irq_v = !((v == VL) && (h < 64));
    con   = fetching(h, v) && ((h % 8) <= 5);
    rgb   = 3'b000;
    ii    = 1'b0;
    if (!(hb || vb)) begin
      if ((v < 192) && (h >= 8) && (h < 264)) begin
        x    = h - 8;
        bm   = mem[bm_addr(v, x / 8)];
        at   = mem[at_addr(v, x / 8)];
        bitv = bm[7 - (x % 8)];
        fl   = at[7] && (((frame / 16) % 2) == 1);
        pix  = bitv ^ fl;
        rgb  = pix ? at[2:0] : at[5:3];
        ii   = at[6];
      end else begin
        rgb = bord;
      end
    end
    return {hs, vs, hb, vb, rgb[1], rgb[2], rgb[0], ii, irq_v, con};
  endfunction

  always @(posedge clock) begin
    if (reset) begin
      ref_h     <= 0;
      ref_v     <= 0;
      ref_frame <= 0;
      last_va   <= 0;
      exp_out   <= RstOut;
    end else if (ce) begin
      exp_out <= outs_at(ref_h, ref_v, border, ref_frame);
      last_va <= va_model(ref_h, ref_v, last_va);
      ref_h   <= (ref_h >= hmax_of(model)) ? 0 : ref_h + 1;
      ref_v   <= next_v(ref_h, ref_v, model);
      if ((ref_v != 0) && (next_v(ref_h, ref_v, model) == 0)) ref_frame <= ref_frame + 1;
    end
  end

  task automatic test_reset();
    reset = 1'b1; ce = 1'b1; model = 1'b0; border = 3'b101;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock); #1;
      total++;
      if ({hsync, vsync, hblank, vblank, r, g, b, i, irq, contend} !== RstOut) begin
        bad++;
        $display("FAIL reset_outs: got %b want %b",
                 {hsync, vsync, hblank, vblank, r, g, b, i, irq, contend}, RstOut);
      end
      total++;
      if (vce !== 1'b0) begin bad++; $display("FAIL reset_vce: got %b want 0", vce); end
      total++;
      if (va !== 13'h0) begin bad++; $display("FAIL reset_va: got %h want 0", va); end
`ifdef ZX_VIDEO_FLOATBUS_EN
      total++;
      if (fb !== 8'hFF) begin bad++; $display("FAIL reset_fb: got %h want ff", fb); end
`endif
    end
  endtask

  task automatic test_random_display();
    int          irq_low = 0;
    int          vs_high = 0;
    logic        e_vce;
    logic [12:0] e_va;
    for (int k = 0; k < 8192; k++) mem[k] = 8'($urandom);
    while (ref_v < 16) begin
      @(negedge clock);
      reset  = 1'b0;
      ce     = ($urandom % 4) != 0;
      border = 3'($urandom);
      #1;
      e_vce = ce && fetching(ref_h, ref_v) && ((ref_h % 8 == 0) || (ref_h % 8 == 2));
      e_va  = 13'(va_model(ref_h, ref_v, last_va));
      total++;
      if ({vce, va} !== {e_vce, e_va}) begin
        bad++;
        $display("FAIL rand_fetch @%0d,%0d: got vce=%b va=%h want vce=%b va=%h",
                 ref_v, ref_h, vce, va, e_vce, e_va);
      end
      @(posedge clock); #1;
      total++;
      if ({hsync, vsync, hblank, vblank, r, g, b, i, irq, contend} !== exp_out) begin
        bad++;
        $display("FAIL rand_outs @%0d,%0d: got %b want %b", ref_v, ref_h,
                 {hsync, vsync, hblank, vblank, r, g, b, i, irq, contend}, exp_out);
      end
      if (ce && !irq) irq_low++;
      if (ce && vsync) vs_high++;
    end
    total++;
    if (irq_low != 64) begin bad++; $display("FAIL irq_width: got %0d want 64", irq_low); end
    total++;
    if (vs_high != 4 * 448) begin
      bad++; $display("FAIL vsync_width: got %0d want %0d", vs_high, 4 * 448);
    end
  endtask

  task automatic test_model1_timing();
    int   rises[$];
    int   hs_cnt = 0;
    int   hb_cnt = 0;
    logic prev_hs;
    prev_hs = hsync;
    for (int k = 0; k < 3 * 456; k++) begin
      @(negedge clock);
      model = 1'b1; ce = 1'b1; border = 3'($urandom);
      @(posedge clock); #1;
      total++;
      if ({hsync, vsync, hblank, vblank, r, g, b, i, irq, contend} !== exp_out) begin
        bad++;
        $display("FAIL m1_outs @%0d,%0d: got %b want %b", ref_v, ref_h,
                 {hsync, vsync, hblank, vblank, r, g, b, i, irq, contend}, exp_out);
      end
      if (hsync && !prev_hs) rises.push_back(k);
      if (rises.size() == 1) begin
        if (hsync) hs_cnt++;
        if (hblank) hb_cnt++;
      end
      prev_hs = hsync;
    end
    total++;
    if (rises.size() < 2) begin
      bad++; $display("FAIL m1_hsync_edges: got %0d want >=2", rises.size());
    end else if (rises[1] - rises[0] != 456) begin
      bad++; $display("FAIL m1_line_len: got %0d want 456", rises[1] - rises[0]);
    end
    total++;
    if (hs_cnt != 32) begin bad++; $display("FAIL m1_hsync_width: got %0d want 32", hs_cnt); end
    total++;
    if (hb_cnt != 96) begin bad++; $display("FAIL m1_hblank_width: got %0d want 96", hb_cnt); end
  endtask

  task automatic test_addresses();
    while (!(ref_v == 65 && ref_h == 24)) begin @(negedge clock); ce = 1'b1; end
    #1;
    total++;
    if ({vce, va} !== {1'b1, 13'h0903}) begin
      bad++; $display("FAIL addr_bitmap: got vce=%b va=%h want vce=1 va=0903", vce, va);
    end
    @(negedge clock); #1;
    total++;
    if ({vce, va} !== {1'b0, 13'h0903}) begin
      bad++; $display("FAIL addr_hold: got vce=%b va=%h want vce=0 va=0903", vce, va);
    end
    @(negedge clock); #1;
    total++;
    if ({vce, va} !== {1'b1, 13'h1903}) begin
      bad++; $display("FAIL addr_attr: got vce=%b va=%h want vce=1 va=1903", vce, va);
    end
  endtask

  task automatic test_model_shrink();
    logic [12:0] e_va;
    while (!(ref_v == 65 && ref_h == 450)) @(negedge clock);
    model = 1'b0; #1;
    total++;
    if (vce !== 1'b0) begin bad++; $display("FAIL shrink_pre_vce: got %b want 0", vce); end
    @(negedge clock); #1;
    e_va = 13'(bm_addr(66, 0));
    total++;
    if ({vce, va} !== {1'b1, e_va}) begin
      bad++; $display("FAIL shrink_wrap: got vce=%b va=%h want vce=1 va=%h", vce, va, e_va);
    end
    while (!(ref_v == 67 && ref_h == 0)) @(negedge clock);
    #1;
    e_va = 13'(bm_addr(67, 0));
    total++;
    if ({vce, va} !== {1'b1, e_va}) begin
      bad++; $display("FAIL m0_line_len: got vce=%b va=%h want vce=1 va=%h", vce, va, e_va);
    end
  endtask

  task automatic test_reset_midframe();
    logic [3:0] want;
    int         x;
    while (!(ref_v == 100 && ref_h == 200)) @(negedge clock);
    reset = 1'b1; border = 3'b010;
    mem[0] = 8'hAA; mem[1] = 8'hAA; mem[6144] = 8'h47; mem[6145] = 8'hB8;
    @(posedge clock); #1;
    total++;
    if ({hsync, vsync, hblank, vblank, r, g, b, i, irq, contend, vce, va} !==
        {RstOut, 1'b0, 13'h0}) begin
      bad++;
      $display("FAIL mid_reset: got %b vce=%b va=%h want %b vce=0 va=0",
               {hsync, vsync, hblank, vblank, r, g, b, i, irq, contend}, vce, va, RstOut);
    end
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0; ce = 1'b1; #1;
    total++;
    if ({vce, va} !== {1'b1, 13'h0}) begin
      bad++; $display("FAIL restart_fetch: got vce=%b va=%h want vce=1 va=0", vce, va);
    end
    for (int h = 0; h < 24; h++) begin
      @(posedge clock); #1;
      if (h == 0 || h >= 8) begin
        x = h - 8;
        if (h == 0) want = 4'b1000;
        else if (x < 8) want = (x % 2 == 0) ? 4'b1111 : 4'b0001;
        else want = (x % 2 == 0) ? 4'b0000 : 4'b1110;
        total++;
        if ({r, g, b, i} !== want) begin
          bad++; $display("FAIL pixel h=%0d: got rgbi=%b want %b", h, {r, g, b, i}, want);
        end
      end
      @(negedge clock);
      ce = 1'b1;
    end
  endtask

  task automatic test_floatbus();
`ifdef ZX_VIDEO_FLOATBUS_EN
    logic [7:0] want;
    @(negedge clock); reset = 1'b1; ce = 1'b1; model = 1'b0;
    mem[0] = 8'hAA; mem[6144] = 8'h47;
    @(negedge clock); reset = 1'b0;
    while (ref_h <= 300) begin
      #1;
      if (ref_h <= 5 || ref_h == 300) begin
        case (ref_h)
          1, 2:    want = 8'hAA;
          3, 4:    want = 8'h47;
          default: want = 8'hFF;
        endcase
        total++;
        if (fb !== want) begin
          bad++; $display("FAIL fb h=%0d: got %h want %h", ref_h, fb, want);
        end
      end
      @(negedge clock);
    end
`endif
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_random_display();
    test_model1_timing();
    test_addresses();
    test_model_shrink();
    test_reset_midframe();
    test_floatbus();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
